key_sched_ctrl: RTL and testbench

Sequential AES-128 key-schedule controller. It accepts a 128-bit cipher key through a valid/ready handshake. It then iterates a single shared round-step unit for NR cycles, producing one round key per cycle into an 11-entry round-key store. The round/cipher core reads keys back through an indexed, registered read port, which replaces the flat all-combinational expansion with a 4-S-box, one-round-per-cycle datapath.

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/key_round_step.sv | 42 ++++
 rtl/key_sched_ctrl.sv | 169 ++++++++++++++++
 tb/tb_key_sched_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 constants and helpers for the key-schedule datapath:
//   AES_NR / AES_KEY_W / AES_IDX_W : round count, key width, round-key index width
//   rk_idx_t                       : round-key index type
//   aes_rcon(r)                    : round constant byte for round r (1..10)
//   aes_sbox(x)                    : forward AES S-box lookup
// ----------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_KEY_W = 128;
    localparam int AES_IDX_W = 4;

    typedef logic [AES_IDX_W-1:0] rk_idx_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        return SBOX_TABLE[(255 - int'(x)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] aes_rcon(input rk_idx_t r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/key_round_step.sv
// ----------------------------------------------------------------------------
// key_round_step
// Purely combinational AES-128 key-expansion step: one round key in, the next
// round key out. Uses four S-box lookups on the rotated last word.
// Ports:
//   prev_key  in  128  previous round key, word0 = prev_key[127:96]
//   rcon      in  8    round constant byte for the key being produced
//   next_key  out 128  next round key, word0 = next_key[127:96]
// ----------------------------------------------------------------------------
module key_round_step
    import aes_pkg::*;
(
    input  logic [AES_KEY_W-1:0] prev_key,
    input  logic [7:0]           rcon,
    output logic [AES_KEY_W-1:0] next_key
);

    logic [31:0] rot_w3;
    logic [31:0] sub_w;
    logic [31:0] nw0;
    logic [31:0] nw1;
    logic [31:0] nw2;
    logic [31:0] nw3;

    // RotWord: left byte rotate of w3 (the least significant word).
    assign rot_w3 = {prev_key[23:0], prev_key[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_w[gi*8 +: 8] = aes_sbox(rot_w3[gi*8 +: 8]);
        end
    endgenerate

    assign nw0 = prev_key[127:96] ^ sub_w ^ {rcon, 24'h000000};
    assign nw1 = prev_key[95:64]  ^ nw0;
    assign nw2 = prev_key[63:32]  ^ nw1;
    assign nw3 = prev_key[31:0]   ^ nw2;

    assign next_key = {nw0, nw1, nw2, nw3};

endmodule

// File: rtl/key_sched_ctrl.sv
// ----------------------------------------------------------------------------
// key_sched_ctrl
// Sequential AES-128 key-schedule controller. A cipher key is accepted via a
// valid/ready handshake, then one round key per cycle is produced by a single
// shared key_round_step into an (NR+1)-entry store. Keys are read back through
// an indexed, registered read port.
// Optional build macro: KEY_SCHED_ZEROIZE_EN adds a zeroize input that clears
// the store and aborts any expansion, with priority over accept and read.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   zeroize      (KEY_SCHED_ZEROIZE_EN only) clear all key material
//   key_in       cipher key, word0 = key_in[127:96]
//   key_valid    key_in valid
//   key_ready    controller can accept a key (IDLE or READY)
//   rd_en/rd_idx round-key read request / index 0..NR
//   rd_data      registered round key
//   rd_valid     rd_data valid pulse
//   rd_err       read-rejected pulse
//   keys_valid   full schedule stored for the current key
//   busy         expansion in progress
//   done         pulse on the edge that writes round key NR
// ----------------------------------------------------------------------------
module key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int KEY_W = AES_KEY_W,
    parameter int IDX_W = AES_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
`ifdef KEY_SCHED_ZEROIZE_EN
    input  logic             zeroize,
`endif
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [KEY_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_err,
    output logic             keys_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;

    logic [1:0]       state_reg;
    logic [IDX_W-1:0] round_reg;
    logic [KEY_W-1:0] rk_reg [NR+1];
    logic [KEY_W-1:0] rd_data_reg;
    logic             rd_valid_reg;
    logic             rd_err_reg;
    logic             keys_valid_reg;
    logic             done_reg;

    logic             zero_req;
    logic             accept;
    logic [IDX_W-1:0] prev_idx;
    logic [KEY_W-1:0] step_in;
    logic [KEY_W-1:0] step_out;
    logic [7:0]       step_rcon;

`ifdef KEY_SCHED_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    // Zeroize also blocks acceptance so a key cannot slip in on the wipe edge.
    assign key_ready = ((state_reg == ST_IDLE) || (state_reg == ST_READY)) && !zero_req;
    assign accept    = key_valid && key_ready;
    assign busy      = (state_reg == ST_EXPAND);

    // Outside EXPAND the counter is 0; clamp so the index stays in range.
    assign prev_idx  = (round_reg == '0) ? '0 : round_reg - 1'b1;
    assign step_in   = rk_reg[prev_idx];
    assign step_rcon = aes_rcon(rk_idx_t'(round_reg));

    key_round_step u_step (
        .prev_key (step_in),
        .rcon     (step_rcon),
        .next_key (step_out)
    );

    // Control: state, round counter, status flags.
    always_ff @(posedge clk) begin
        if (rst || zero_req) begin
            state_reg      <= ST_IDLE;
            round_reg      <= '0;
            keys_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_READY: begin
                    if (accept) begin
                        state_reg      <= ST_EXPAND;
                        round_reg      <= IDX_W'(1);
                        keys_valid_reg <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    if (round_reg == IDX_W'(NR)) begin
                        state_reg      <= ST_READY;
                        round_reg      <= '0;
                        keys_valid_reg <= 1'b1;
                        done_reg       <= 1'b1;
                    end else begin
                        round_reg <= round_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    round_reg <= '0;
                end
            endcase
        end
    end

    // Round-key store: entry 0 takes the cipher key, entry r the step output.
    always_ff @(posedge clk) begin
        for (int i = 0; i <= NR; i++) begin
            if (rst || zero_req) begin
                rk_reg[i] <= '0;
            end else if ((i == 0) && accept) begin
                rk_reg[i] <= key_in;
            end else if ((state_reg == ST_EXPAND) && (round_reg == IDX_W'(i))) begin
                rk_reg[i] <= step_out;
            end
        end
    end

    // Registered read port. Uses pre-edge store contents, so a read that
    // coincides with a re-key returns the old schedule.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            rd_err_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= 1'b0;
            rd_err_reg   <= 1'b0;
            if (zero_req) begin
                rd_data_reg <= '0;
                rd_err_reg  <= rd_en;
            end else if (rd_en) begin
                if (keys_valid_reg && (rd_idx <= IDX_W'(NR))) begin
                    rd_data_reg  <= rk_reg[rd_idx];
                    rd_valid_reg <= 1'b1;
                end else begin
                    rd_data_reg <= '0;
                    rd_err_reg  <= 1'b1;
                end
            end
        end
    end

    assign rd_data    = rd_data_reg;
    assign rd_valid   = rd_valid_reg;
    assign rd_err     = rd_err_reg;
    assign keys_valid = keys_valid_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// ----------------------------------------------------------------------------
// tb_key_sched_ctrl
// Directed bench for key_sched_ctrl using FIPS-197 and all-zero key vectors.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         zeroize;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         rd_en;
    logic [3:0]   rd_idx;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic         rd_err;
    logic         keys_valid;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK2   = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    always #5 clk = ~clk;

    key_sched_ctrl dut (
        .clk        (clk),
        .rst        (rst),
`ifdef KEY_SCHED_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_err     (rd_err),
        .keys_valid (keys_valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [3:0] idx);
        rd_idx = idx;
        rd_en  = 1'b1;
        tick();
        rd_en  = 1'b0;
        $display("read idx=%0d valid=%0b err=%0b data=%h", idx, rd_valid, rd_err, rd_data);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready: got %b expected 1", key_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL reset_keys_valid: got %b expected 0", keys_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (rd_data !== 128'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        checks++; if ({rd_valid, rd_err} !== 2'b00) begin errors++; $display("FAIL reset_rd_flags: got %b expected 00", {rd_valid, rd_err}); end
        do_read(4'd0);
        checks++; if ({rd_valid, rd_err} !== 2'b01) begin errors++; $display("FAIL idle_read: got valid/err %b expected 01", {rd_valid, rd_err}); end
    endtask

    task automatic test_expand_fips();
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        #1;
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL expand_ready: got %b expected 1", key_ready); end
        tick();   // E0
        key_valid = 1'b0;
        $display("accept key=%h", FIPS_KEY);
        for (int i = 1; i <= 10; i++) begin
            if (busy === 1'b1) busy_cnt++;
            tick(); // Ei
            if (done === 1'b1) done_cnt++;
            if (i == 9) begin
                checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL early_keys_valid: got %b expected 0 after E9", keys_valid); end
            end
        end
        checks++; if (busy_cnt != 10) begin errors++; $display("FAIL busy_cycles: got %0d expected 10", busy_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL done_count: got %0d expected 1", done_cnt); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_at_E10: got %b expected 1", done); end
        checks++; if (keys_valid !== 1'b1) begin errors++; $display("FAIL keys_valid_E10: got %b expected 1", keys_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after: got %b expected 0", busy); end
        do_read(4'd1);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b expected 0", done); end
        checks++; if (rd_data !== FIPS_RK1 || rd_valid !== 1'b1 || rd_err !== 1'b0) begin errors++; $display("FAIL fips_rk1: got %h v=%b e=%b expected %h v=1 e=0", rd_data, rd_valid, rd_err, FIPS_RK1); end
        do_read(4'd2);
        checks++; if (rd_data !== FIPS_RK2) begin errors++; $display("FAIL fips_rk2: got %h expected %h", rd_data, FIPS_RK2); end
        do_read(4'd10);
        checks++; if (rd_data !== FIPS_RK10) begin errors++; $display("FAIL fips_rk10: got %h expected %h", rd_data, FIPS_RK10); end
        do_read(4'd0);
        checks++; if (rd_data !== FIPS_KEY) begin errors++; $display("FAIL fips_rk0: got %h expected %h", rd_data, FIPS_KEY); end
        tick();
        checks++; if (rd_valid !== 1'b0 || rd_data !== FIPS_KEY) begin errors++; $display("FAIL read_hold: got v=%b data=%h expected v=0 data=%h", rd_valid, rd_data, FIPS_KEY); end
    endtask

    task automatic test_bad_index();
        do_read(4'd11);
        checks++; if ({rd_valid, rd_err} !== 2'b01 || rd_data !== 128'h0) begin errors++; $display("FAIL idx11: got v/e=%b data=%h expected 01 and 0", {rd_valid, rd_err}, rd_data); end
        do_read(4'd15);
        checks++; if ({rd_valid, rd_err} !== 2'b01 || rd_data !== 128'h0) begin errors++; $display("FAIL idx15: got v/e=%b data=%h expected 01 and 0", {rd_valid, rd_err}, rd_data); end
        tick();
        checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b expected 0", rd_err); end
    endtask

    task automatic test_read_and_rekey();
        key_in    = 128'h0;
        key_valid = 1'b1;
        rd_idx    = 4'd0;
        rd_en     = 1'b1;
        tick();
        key_valid = 1'b0;
        rd_en     = 1'b0;
        $display("rekey+read idx=0 valid=%0b data=%h keys_valid=%0b", rd_valid, rd_data, keys_valid);
        checks++; if (rd_valid !== 1'b1 || rd_data !== FIPS_KEY) begin errors++; $display("FAIL rekey_read_old: got v=%b data=%h expected v=1 data=%h", rd_valid, rd_data, FIPS_KEY); end
        checks++; if (keys_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rekey_status: got kv=%b busy=%b expected kv=0 busy=1", keys_valid, busy); end
        for (int i = 0; i < 10; i++) tick();
        do_read(4'd1);
        checks++; if (rd_data !== ZERO_RK1) begin errors++; $display("FAIL zero_rk1: got %h expected %h", rd_data, ZERO_RK1); end
    endtask

    task automatic test_hold_during_expand();
        int ready_hi;
        int done_cnt;
        ready_hi = 0;
        done_cnt = 0;
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        tick();   // E0
        key_in = 128'h0;  // second key held through the expansion
        for (int i = 1; i <= 10; i++) begin
            if (key_ready !== 1'b0) ready_hi++;
            if (i == 5) begin
                rd_idx = 4'd5;
                rd_en  = 1'b1;
            end
            tick();
            if (i == 5) begin
                rd_en = 1'b0;
                $display("read during expand idx=5 valid=%0b err=%0b", rd_valid, rd_err);
                checks++; if ({rd_valid, rd_err} !== 2'b01) begin errors++; $display("FAIL expand_read: got v/e=%b expected 01", {rd_valid, rd_err}); end
            end
            if (done === 1'b1) done_cnt++;
        end
        checks++; if (ready_hi != 0) begin errors++; $display("FAIL hold_ready: got %0d cycles ready expected 0", ready_hi); end
        checks++; if (done_cnt != 1 || keys_valid !== 1'b1) begin errors++; $display("FAIL hold_done: got done=%0d kv=%b expected 1 and 1", done_cnt, keys_valid); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_E10: got %b expected 1", key_ready); end
        tick();   // second key accepted on first READY cycle
        key_valid = 1'b0;
        checks++; if (keys_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL second_accept: got kv=%b busy=%b expected 0/1", keys_valid, busy); end
        for (int i = 0; i < 10; i++) tick();
        do_read(4'd10);
        checks++; if (rd_data !== ZERO_RK10) begin errors++; $display("FAIL zero_rk10: got %h expected %h", rd_data, ZERO_RK10); end
    endtask

    task automatic test_rst_mid_expand();
        int done_cnt;
        done_cnt = 0;
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        tick();   // E0
        key_valid = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        rst = 1'b1;
        tick();   // E5
        rst = 1'b0;
        $display("rst at E5 busy=%0b keys_valid=%0b", busy, keys_valid);
        checks++; if (busy !== 1'b0 || keys_valid !== 1'b0 || key_ready !== 1'b1) begin errors++; $display("FAIL rst_state: got busy=%b kv=%b ready=%b expected 0/0/1", busy, keys_valid, key_ready); end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL rst_no_done: got %0d expected 0", done_cnt); end
        do_read(4'd0);
        checks++; if ({rd_valid, rd_err} !== 2'b01) begin errors++; $display("FAIL rst_read: got v/e=%b expected 01", {rd_valid, rd_err}); end
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        do_read(4'd10);
        checks++; if (rd_data !== FIPS_RK10) begin errors++; $display("FAIL rst_reexpand: got %h expected %h", rd_data, FIPS_RK10); end
    endtask

`ifdef KEY_SCHED_ZEROIZE_EN
    task automatic test_zeroize();
        int nonzero;
        nonzero = 0;
        zeroize   = 1'b1;
        rd_en     = 1'b1;
        rd_idx    = 4'd1;
        key_in    = 128'h0;
        key_valid = 1'b1;
        #1;
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL zeroize_ready: got %b expected 0", key_ready); end
        tick();
        zeroize   = 1'b0;
        rd_en     = 1'b0;
        key_valid = 1'b0;
        $display("zeroize valid=%0b err=%0b data=%h keys_valid=%0b", rd_valid, rd_err, rd_data, keys_valid);
        checks++; if ({rd_valid, rd_err} !== 2'b01 || rd_data !== 128'h0) begin errors++; $display("FAIL zeroize_read: got v/e=%b data=%h expected 01 and 0", {rd_valid, rd_err}, rd_data); end
        checks++; if (keys_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zeroize_state: got kv=%b busy=%b expected 0/0", keys_valid, busy); end
        for (int i = 0; i <= 10; i++) if (dut.rk_reg[i] !== 128'h0) nonzero++;
        checks++; if (nonzero != 0) begin errors++; $display("FAIL zeroize_store: got %0d nonzero entries expected 0", nonzero); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zeroize_no_accept: got busy=%b expected 0", busy); end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        zeroize   = 1'b0;
        key_in    = '0;
        key_valid = 1'b0;
        rd_en     = 1'b0;
        rd_idx    = '0;
        #1;
        test_reset();
        test_expand_fips();
        test_bad_index();
        test_read_and_rekey();
        test_hold_during_expand();
        test_rst_mid_expand();
`ifdef KEY_SCHED_ZEROIZE_EN
        test_zeroize();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
